// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer.
// Optional stall/flush perf counters under PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int WIDTH = 96,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
`ifdef PIPE_STAGE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             in_fire;
  logic             out_fire;

  // in_ready depends only on registered state
  assign in_ready = !skid_valid;
  assign out_data = main_data;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_data  <= FLUSH_VALUE;
      skid_data  <= FLUSH_VALUE;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_data  <= FLUSH_VALUE;
      skid_data  <= FLUSH_VALUE;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        (!skid_valid && !out_valid): begin
          if (in_fire) begin
            main_data <= in_data;
            out_valid <= 1'b1;
          end
        end
        (!skid_valid && out_valid): begin
          if (in_fire && out_fire) begin
            main_data <= in_data;
          end else if (in_fire) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
          end else if (out_fire) begin
            main_data <= FLUSH_VALUE;
            out_valid <= 1'b0;
          end
        end
        skid_valid: begin
          if (out_fire) begin
            main_data  <= skid_data;
            skid_data  <= FLUSH_VALUE;
            skid_valid <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Saturating counters; flush does not clear them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, directed
// sequences and random traffic against a queue-based reference.
module tb_pipe_stage_reg;
  localparam int W = 96;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mq[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH(W)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt)
    , .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         ov;
    logic         ir;
    logic [W-1:0] od;
  } vec_t;

  task automatic chk(input string nm, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: a FIFO of at most two held beats
  task automatic tick(input logic iv, input logic [W-1:0] d,
                      input logic ordy, input logic fl);
    bit acc;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    acc = iv && (mq.size() < 2);
    if (fl) mq.delete();
    else begin
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
    #1;
  endtask

  task automatic model_chk(input string nm);
    logic [W-1:0] exp_d;
    exp_d = (mq.size() > 0) ? mq[0] : '0;
    chk({nm, "_ov"}, W'(out_valid), W'(mq.size() > 0));
    chk({nm, "_ir"}, W'(in_ready), W'(mq.size() < 2));
    chk({nm, "_data"}, out_data, exp_d);
  endtask

  initial begin
    vec_t tbl[12];
    tbl[0]  = '{1, 96'hA1, 0, 0, 1, 1, 96'hA1};
    tbl[1]  = '{1, 96'hB2, 0, 0, 1, 0, 96'hA1};
    tbl[2]  = '{1, 96'hC3, 0, 0, 1, 0, 96'hA1};
    tbl[3]  = '{1, 96'hC3, 1, 0, 1, 1, 96'hB2};
    tbl[4]  = '{1, 96'hC3, 1, 0, 1, 1, 96'hC3};
    tbl[5]  = '{0, 96'h0,  1, 0, 0, 1, 96'h0};
    tbl[6]  = '{1, 96'h11, 0, 0, 1, 1, 96'h11};
    tbl[7]  = '{1, 96'h22, 0, 0, 1, 0, 96'h11};
    tbl[8]  = '{1, 96'h33, 0, 1, 0, 1, 96'h0};
    tbl[9]  = '{1, 96'h44, 1, 0, 1, 1, 96'h44};
    tbl[10] = '{0, 96'h0,  1, 1, 0, 1, 96'h0};
    tbl[11] = '{1, 96'h55, 1, 1, 0, 1, 96'h0};

    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 96'hFFFF_0000_1234_5678_9ABC_ABCD;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", W'(out_valid), W'(0));
    chk("rst_ir", W'(in_ready), W'(1));
    chk("rst_data", out_data, '0);
    @(negedge clk);
    rst = 1'b1;

    tick(1, 96'hABCD, 1, 0);
    model_chk("first");
    tick(0, '0, 1, 0);
    model_chk("drain");

    foreach (tbl[i]) begin
      tick(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d_ov", i), W'(out_valid), W'(tbl[i].ov));
      chk($sformatf("vec%0d_ir", i), W'(in_ready), W'(tbl[i].ir));
      chk($sformatf("vec%0d_data", i), out_data, tbl[i].od);
    end

    for (int i = 0; i < 8; i++) begin
      tick(1, W'(96'hD0 + i), 1, 0);
      chk($sformatf("stream%0d", i), out_data, W'(96'hD0 + i));
      chk($sformatf("stream%0d_ir", i), W'(in_ready), W'(1));
    end
    tick(0, '0, 1, 0);
    model_chk("stream_end");

    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 3) != 0),
           {$urandom, $urandom, $urandom},
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 9) == 0));
      model_chk($sformatf("rnd%0d", i));
    end

    tick(1, 96'h77, 0, 0);
    tick(1, 96'h88, 0, 0);
    rst = 1'b0;
    #1;
    chk("midrst_ov", W'(out_valid), W'(0));
    chk("midrst_ir", W'(in_ready), W'(1));
    chk("midrst_data", out_data, '0);
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    tick(0, '0, 1, 0);
    model_chk("post_rst");

`ifdef PIPE_STAGE_PERF_EN
    chk("stall_init", W'(stall_cnt), W'(0));
    tick(1, 96'h1, 0, 0);
    tick(1, 96'h2, 0, 0);
    repeat (20) tick(1, 96'h3, 0, 0);
    chk("stall_sat", W'(stall_cnt), W'(15));
    for (int i = 0; i < 3; i++) begin
      tick(0, '0, 0, 1);
      tick(0, '0, 0, 0);
    end
    chk("flush_cnt", W'(flush_cnt), W'(3));
    chk("stall_hold", W'(stall_cnt), W'(15));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
